// File: rtl/psram_arb_pkg.sv
// Shared types and command encodings for the PSRAM burst arbiter.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_GAP      = 2'd3
  } arb_state_e;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/psram_arb_rr.sv
// Two-way round-robin picker: grant bit 0 = writer, bit 1 = reader.
module psram_arb_rr (
  input  logic       wr_req_i,
  input  logic       rd_req_i,
  input  logic       last_rd_i,
  output logic [1:0] gnt_o,
  output logic       last_rd_o
);

  always_comb begin
    gnt_o     = 2'b00;
    last_rd_o = last_rd_i;
    if (wr_req_i && rd_req_i) begin
      // Contention goes to whoever was not served last.
      gnt_o = last_rd_i ? 2'b01 : 2'b10;
    end else if (wr_req_i) begin
      gnt_o = 2'b01;
    end else if (rd_req_i) begin
      gnt_o = 2'b10;
    end
    if (gnt_o[1]) begin
      last_rd_o = 1'b1;
    end else if (gnt_o[0]) begin
      last_rd_o = 1'b0;
    end
  end

endmodule

// File: rtl/psram_burst_arbiter.sv
// Shares the PSRAM command port between a burst writer and a burst reader,
// one fixed-length burst at a time, with command spacing and read timeout.
module psram_burst_arbiter
  import psram_arb_pkg::*;
#(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 64,
  parameter int BURST_WORDS = 16,
  parameter int TRC         = 24,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_calib,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_gnt,
  output logic              wr_data_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              psram_cmd,
  output logic              psram_cmd_en,
  output logic [ADDR_W-1:0] psram_addr,
  output logic [DATA_W-1:0] psram_write_data,
  input  logic [DATA_W-1:0] psram_read_data,
  input  logic              psram_read_data_valid,
  output logic              busy,
  output logic              err_rd_timeout,
  output logic              err_spurious,
  output logic [1:0]        dbg_state
);

  localparam int CNT_MAX = (TRC > RD_TIMEOUT) ? TRC : RD_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BEAT_W  = $clog2(BURST_WORDS + 1);
  localparam logic [CNT_W-1:0]  GAP_END   = CNT_W'(TRC - 2);
  localparam logic [CNT_W-1:0]  TO_END    = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_WORDS - 1);

  if (TRC < BURST_WORDS + 1) begin : g_trc_chk
    $error("TRC must be at least BURST_WORDS+1");
  end

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              last_rd_q, last_rd_d;
  logic              cmd_en_q, cmd_en_d;
  logic              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              rdv_q, rdv_d;
  logic [DATA_W-1:0] rdd_q, rdd_d;
  logic              err_to_q, err_to_d;
  logic              err_sp_q, err_sp_d;
  logic [1:0]        rr_gnt;
  logic              rr_last_rd;

  psram_arb_rr u_rr (
    .wr_req_i  (wr_req),
    .rd_req_i  (rd_req),
    .last_rd_i (last_rd_q),
    .gnt_o     (rr_gnt),
    .last_rd_o (rr_last_rd)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      beat_q    <= '0;
      last_rd_q <= 1'b1;
      cmd_en_q  <= 1'b0;
      cmd_q     <= 1'b0;
      addr_q    <= '0;
      wr_gnt_q  <= 1'b0;
      rd_gnt_q  <= 1'b0;
      rdv_q     <= 1'b0;
      rdd_q     <= '0;
      err_to_q  <= 1'b0;
      err_sp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      beat_q    <= beat_d;
      last_rd_q <= last_rd_d;
      cmd_en_q  <= cmd_en_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wr_gnt_q  <= wr_gnt_d;
      rd_gnt_q  <= rd_gnt_d;
      rdv_q     <= rdv_d;
      rdd_q     <= rdd_d;
      err_to_q  <= err_to_d;
      err_sp_q  <= err_sp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = (cyc_q == CNT_SAT) ? cyc_q : cyc_q + 1'b1;
    beat_d    = beat_q;
    last_rd_d = last_rd_q;
    cmd_en_d  = 1'b0;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wr_gnt_d  = 1'b0;
    rd_gnt_d  = 1'b0;
    rdv_d     = 1'b0;
    rdd_d     = rdd_q;
    err_to_d  = err_to_q;
    err_sp_d  = err_sp_q | (psram_read_data_valid && (state_q != ST_RD_WAIT));
    unique case (state_q)
      ST_IDLE: begin
        if (init_calib && (rr_gnt != 2'b00)) begin
          cmd_en_d  = 1'b1;
          cyc_d     = '0;
          beat_d    = '0;
          last_rd_d = rr_last_rd;
          if (rr_gnt[0]) begin
            state_d  = ST_WR_BURST;
            cmd_d    = CMD_WRITE;
            addr_d   = wr_addr;
            wr_gnt_d = 1'b1;
          end else begin
            state_d  = ST_RD_WAIT;
            cmd_d    = CMD_READ;
            addr_d   = rd_addr;
            rd_gnt_d = 1'b1;
          end
        end
      end
      ST_WR_BURST: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = ST_GAP;
        end
      end
      ST_RD_WAIT: begin
        // A final beat landing on the timeout cycle still counts as success.
        if (psram_read_data_valid) begin
          rdv_d  = 1'b1;
          rdd_d  = psram_read_data;
          beat_d = beat_q + 1'b1;
        end
        if (psram_read_data_valid && (beat_q == LAST_BEAT)) begin
          state_d = ST_GAP;
        end else if (cyc_q >= TO_END) begin
          err_to_d = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        // Leave two cycles early so the IDLE sample plus the registered
        // cmd_en land exactly TRC after the previous command.
        if (cyc_q >= GAP_END) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_gnt           = wr_gnt_q;
  assign rd_gnt           = rd_gnt_q;
  assign wr_data_en       = (state_q == ST_WR_BURST);
  assign psram_write_data = wr_data_en ? wr_data : '0;
  assign rd_data_valid    = rdv_q;
  assign rd_data          = rdd_q;
  assign psram_cmd        = cmd_q;
  assign psram_cmd_en     = cmd_en_q;
  assign psram_addr       = addr_q;
  assign busy             = (state_q != ST_IDLE);
  assign err_rd_timeout   = err_to_q;
  assign err_spurious     = err_sp_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_psram_burst_arbiter.sv
// Directed bench for psram_burst_arbiter with a small PSRAM read model,
// a FWFT write-data driver and a read-data scoreboard.
module tb_psram_burst_arbiter;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 64;

  logic              clk;
  logic              sys_rst_n;
  logic              init_calib;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_gnt;
  logic              wr_data_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  logic              psram_cmd;
  logic              psram_cmd_en;
  logic [ADDR_W-1:0] psram_addr;
  logic [DATA_W-1:0] psram_write_data;
  logic [DATA_W-1:0] psram_read_data;
  logic              psram_read_data_valid;
  logic              busy;
  logic              err_rd_timeout;
  logic              err_spurious;
  logic [1:0]        dbg_state;

  logic              model_valid;
  logic [DATA_W-1:0] model_data;
  logic              spur_valid;
  int                model_lat;
  int                model_beats;

  logic [DATA_W-1:0] exp_q[$];
  int                exp_t_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int wr_beats = 0;
  int rd_beats = 0;

  assign psram_read_data       = model_data;
  assign psram_read_data_valid = model_valid | spur_valid;

  psram_burst_arbiter dut (
    .sys_clk               (clk),
    .sys_rst_n             (sys_rst_n),
    .init_calib            (init_calib),
    .wr_req                (wr_req),
    .wr_addr               (wr_addr),
    .wr_gnt                (wr_gnt),
    .wr_data_en            (wr_data_en),
    .wr_data               (wr_data),
    .rd_req                (rd_req),
    .rd_addr               (rd_addr),
    .rd_gnt                (rd_gnt),
    .rd_data_valid         (rd_data_valid),
    .rd_data               (rd_data),
    .psram_cmd             (psram_cmd),
    .psram_cmd_en          (psram_cmd_en),
    .psram_addr            (psram_addr),
    .psram_write_data      (psram_write_data),
    .psram_read_data       (psram_read_data),
    .psram_read_data_valid (psram_read_data_valid),
    .busy                  (busy),
    .err_rd_timeout        (err_rd_timeout),
    .err_spurious          (err_spurious),
    .dbg_state             (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n = cyc_n + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc_n);
    end
  endtask

  task automatic wait_cmd(input int max_cyc);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!psram_cmd_en && k < max_cyc);
    check_eq("cmd_wait", psram_cmd_en, 1'b1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (busy && k < max_cyc);
    check_eq("idle_wait", busy, 1'b0);
  endtask

  // FWFT write requester: presents word index each beat, checks pass-through and gating
  initial begin
    wr_data = '0;
    forever begin
      @(posedge clk); #1;
      if (psram_cmd_en && psram_cmd) wr_beats = 0;
      if (wr_data_en) begin
        wr_data = 64'(wr_beats);
        #1;
        if (wr_data_en) begin
          check_eq("wr_beat", psram_write_data, 64'(wr_beats));
          wr_beats++;
        end
      end else begin
        wr_data = 64'hDEAD_BEEF_0000_00FF;
        #1;
        if (!wr_data_en) check_eq("wr_gate", psram_write_data, 64'd0);
      end
    end
  end

  // PSRAM read model: after each read command, returns model_beats beats
  initial begin
    logic [ADDR_W-1:0] a;
    model_valid = 1'b0;
    model_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (psram_cmd_en && (psram_cmd == 1'b0)) begin
        a = psram_addr;
        repeat (model_lat) @(posedge clk);
        #1;
        for (int i = 0; i < model_beats; i++) begin
          model_valid = 1'b1;
          model_data  = {27'd0, a, 16'(i)};
          exp_q.push_back(model_data);
          exp_t_q.push_back(cyc_n);
          @(posedge clk); #1;
        end
        model_valid = 1'b0;
      end
    end
  end

  // Read scoreboard: data and one-cycle latency
  initial begin
    logic [DATA_W-1:0] e;
    int t;
    forever begin
      @(posedge clk); #1;
      if (rd_data_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("rd_unexpected", rd_data_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          check_eq("rd_data", rd_data, e);
          check_eq("rd_latency", 64'(cyc_n - t), 64'd1);
          rd_beats++;
        end
      end
    end
  end

  initial begin
    int n, t0, t1;
    int tc[4];
    logic exp_cmd;
    init_calib  = 1'b0;
    wr_req      = 1'b0;
    rd_req      = 1'b0;
    wr_addr     = '0;
    rd_addr     = '0;
    spur_valid  = 1'b0;
    model_lat   = 10;
    model_beats = 16;
    sys_rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cmd_en", psram_cmd_en, 1'b0);
    check_eq("rst_cmd", psram_cmd, 1'b0);
    check_eq("rst_addr", psram_addr, 0);
    check_eq("rst_wr_gnt", wr_gnt, 1'b0);
    check_eq("rst_rd_gnt", rd_gnt, 1'b0);
    check_eq("rst_wr_data_en", wr_data_en, 1'b0);
    check_eq("rst_rd_valid", rd_data_valid, 1'b0);
    check_eq("rst_err_to", err_rd_timeout, 1'b0);
    check_eq("rst_err_sp", err_spurious, 1'b0);
    check_eq("rst_state", dbg_state, 2'd0);
    sys_rst_n = 1'b1;
    @(posedge clk); #1;

    // Uncalibrated: no command; then a write one cycle after calibration
    wr_addr = 21'h01234;
    wr_req  = 1'b1;
    n = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (psram_cmd_en || busy) n++;
    end
    check_eq("uncal_no_cmd", n, 0);
    init_calib = 1'b1;
    @(posedge clk); #1;
    check_eq("t1_cmd_en", psram_cmd_en, 1'b1);
    check_eq("t1_cmd", psram_cmd, 1'b1);
    check_eq("t1_wr_gnt", wr_gnt, 1'b1);
    check_eq("t1_addr", psram_addr, 21'h01234);
    check_eq("t1_wr_data_en", wr_data_en, 1'b1);
    wr_req = 1'b0;
    wait_idle(60);
    check_eq("t1_beats", wr_beats, 16);

    // Single read of 0x000100, beats 10 cycles after cmd_en
    rd_addr = 21'h000100;
    rd_req  = 1'b1;
    wait_cmd(10);
    check_eq("t3_cmd", psram_cmd, 1'b0);
    check_eq("t3_rd_gnt", rd_gnt, 1'b1);
    check_eq("t3_wr_gnt", wr_gnt, 1'b0);
    check_eq("t3_addr", psram_addr, 21'h000100);
    rd_req = 1'b0;
    wait_idle(80);
    check_eq("t3_rd_beats", rd_beats, 16);
    check_eq("t3_exp_empty", exp_q.size(), 0);
    check_eq("t3_err_to", err_rd_timeout, 1'b0);
    check_eq("t3_err_sp", err_spurious, 1'b0);

    // Contention: W,R,W,R exactly 24 cycles apart
    model_lat = 3;
    wr_addr = 21'h0AAAA;
    rd_addr = 21'h15555;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cmd(40);
      tc[i] = cyc_n;
      exp_cmd = (i % 2 == 0);
      check_eq("t2_cmd", psram_cmd, exp_cmd);
      check_eq("t2_wr_gnt", wr_gnt, exp_cmd);
      check_eq("t2_rd_gnt", rd_gnt, !exp_cmd);
      check_eq("t2_addr", psram_addr, exp_cmd ? 21'h0AAAA : 21'h15555);
      if (i > 0) check_eq("t2_spacing", tc[i] - tc[i-1], 24);
      if (i % 2 == 1) check_eq("t2_wr_beats", wr_beats, 16);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    wait_idle(60);
    check_eq("t2_rd_beats", rd_beats, 48);

    // Read with a missing beat times out; pending write then served
    model_lat   = 10;
    model_beats = 15;
    rd_addr = 21'h00200;
    rd_req  = 1'b1;
    wait_cmd(40);
    t0 = cyc_n;
    check_eq("t4_cmd", psram_cmd, 1'b0);
    rd_req  = 1'b0;
    wr_addr = 21'h00300;
    wr_req  = 1'b1;
    t1 = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (err_rd_timeout) begin
        t1 = cyc_n;
        break;
      end
    end
    check_eq("t4_err_to", err_rd_timeout, 1'b1);
    check_eq("t4_timeout_cycle", t1 - t0, 255);
    check_eq("t4_rd_beats", rd_beats, 63);
    wait_cmd(40);
    check_eq("t4_wr_cmd", psram_cmd, 1'b1);
    check_eq("t4_wr_addr", psram_addr, 21'h00300);
    wr_req = 1'b0;
    wait_idle(60);
    check_eq("t4_wr_beats", wr_beats, 16);
    check_eq("t4_err_sp", err_spurious, 1'b0);

    // Lone read beat while idle
    spur_valid = 1'b1;
    @(posedge clk); #1;
    spur_valid = 1'b0;
    check_eq("t5_err_sp", err_spurious, 1'b1);
    check_eq("t5_rd_valid", rd_data_valid, 1'b0);
    check_eq("t5_busy", busy, 1'b0);
    @(posedge clk); #1;
    check_eq("t5_rd_valid_next", rd_data_valid, 1'b0);

    // Reset at write beat 7, then a fresh full burst
    wr_addr = 21'h00400;
    wr_req  = 1'b1;
    wait_cmd(10);
    wr_req = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_eq("t6_beat7_en", wr_data_en, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    check_eq("t6_rst_en", wr_data_en, 1'b0);
    check_eq("t6_rst_busy", busy, 1'b0);
    check_eq("t6_rst_wdata", psram_write_data, 64'd0);
    check_eq("t6_rst_addr", psram_addr, 0);
    check_eq("t6_rst_err_sp", err_spurious, 1'b0);
    check_eq("t6_rst_state", dbg_state, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    wr_req    = 1'b1;
    wait_cmd(10);
    check_eq("t6_cmd", psram_cmd, 1'b1);
    check_eq("t6_wr_gnt", wr_gnt, 1'b1);
    wr_req = 1'b0;
    wait_idle(60);
    check_eq("t6_wr_beats", wr_beats, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
